// File: rtl/mem_xform_pkg.sv
// Shared opcodes, FSM encodings and widths for the mem_xform_port block.
package mem_xform_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [OP_W-1:0] OP_WRITE    = 2'b00;
  localparam logic [OP_W-1:0] OP_READ     = 2'b01;
  localparam logic [OP_W-1:0] OP_READ_INV = 2'b10;
  localparam logic [OP_W-1:0] OP_RMW_INC  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/spmem_core.sv
// Single-port RAM: synchronous write, registered read-first output, no reset.
module spmem_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] out_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= data_i;
    out_o <= mem[addr_i];
  end

endmodule

// File: rtl/mem_xform_port.sv
// Valid/ready front end to a single-port RAM with read, inverted read and
// atomic increment; one read-type access in flight at a time.
module mem_xform_port
  import mem_xform_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [OP_W-1:0]       req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [CNT_W-1:0]      rsp_count_o
);

  state_e                state_q;
  logic [OP_W-1:0]       op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [CNT_W-1:0]      rsp_count_q;

  logic                  accept_c;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign req_ready_o = (state_q == S_IDLE);
  assign accept_c    = req_valid_i && req_ready_o;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_count_o = rsp_count_q;

  // RAM port mux: requester owns the port in IDLE, the latched access in READ
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = req_addr_i;
    mem_wdata_c = req_wdata_i;
    if (state_q == S_READ) begin
      mem_addr_c  = addr_q;
      mem_wdata_c = mem_rdata + DATA_WIDTH'(1);
      mem_we_c    = (op_q == OP_RMW_INC);
    end else if (state_q == S_IDLE) begin
      mem_we_c = accept_c && (req_op_i == OP_WRITE);
    end
  end

  spmem_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we_i  (mem_we_c),
    .addr_i(mem_addr_c),
    .data_i(mem_wdata_c),
    .out_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c && (req_op_i != OP_WRITE)) begin
            op_q    <= req_op_i;
            addr_q  <= req_addr_i;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          rsp_data_q  <= (op_q == OP_READ_INV) ? ~mem_rdata : mem_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_count_q <= rsp_count_q + CNT_W'(1);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xform_port.sv
// Directed scoreboard bench for mem_xform_port at 32x16 and 8x4 configurations.
module tb_mem_xform_port;
  import mem_xform_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 4;
  localparam int unsigned BDW = 8;
  localparam int unsigned BAW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, rsp_data;
  logic [15:0]   rsp_count;

  logic           b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [1:0]     b_req_op;
  logic [BAW-1:0] b_req_addr;
  logic [BDW-1:0] b_req_wdata, b_rsp_data;
  logic [15:0]    b_rsp_count;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [16];
  logic [DW-1:0] exp_q [$];
  logic [15:0]   exp_count = '0;
  logic [BDW-1:0] bvals [4] = '{8'h3C, 8'hA5, 8'h0F, 8'hF0};

  always #5 clk = ~clk;

  mem_xform_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_count_o(rsp_count)
  );

  mem_xform_port #(.DATA_WIDTH(BDW), .ADDR_WIDTH(BAW)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_op_i(b_req_op),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
    .rsp_count_o(b_rsp_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one request; returns at the falling edge after the accept edge.
  task automatic a_send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic a_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    model[addr] = data;
    a_send(OP_WRITE, addr, data);
  endtask

  // Waits for a response with rsp_ready high, compares it to the scoreboard head.
  task automatic a_collect(input string tag);
    int n;
    logic [DW-1:0] exp;
    n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    if (!rsp_valid) begin
      check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    end else begin
      check({tag, "_data"}, rsp_data, exp);
      @(posedge clk);
      @(negedge clk);
      exp_count = exp_count + 16'd1;
      check({tag, "_count"}, 32'(rsp_count), 32'(exp_count));
      check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic a_read(input string tag, input logic [1:0] op, input logic [AW-1:0] addr);
    logic [DW-1:0] m;
    m = model[addr];
    exp_q.push_back((op == OP_READ_INV) ? ~m : m);
    if (op == OP_RMW_INC) model[addr] = m + 32'd1;
    a_send(op, addr, '0);
    check({tag, "_lat_e1"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({tag, "_lat_e2"}, 32'(rsp_valid), 32'd1);
    a_collect(tag);
  endtask

  initial begin
    int n;
    req_valid = 1'b0; req_op = OP_WRITE; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_op = OP_WRITE; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);

    a_write(4'd3, 32'h0000_00A5);
    a_read("read3", OP_READ, 4'd3);
    a_read("rinv3", OP_READ_INV, 4'd3);
    check("rinv_const", model[3] ^ 32'hFFFF_FFFF, 32'hFFFF_FF5A);

    a_write(4'd7, 32'hFFFF_FFFF);
    a_read("rmw7", OP_RMW_INC, 4'd7);
    a_read("read7_wrap", OP_READ, 4'd7);

    // Backpressure: response held 5 cycles while a write to addr 3 is offered
    rsp_ready = 1'b0;
    exp_q.push_back(model[3]);
    a_send(OP_READ, 4'd3, '0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op = OP_WRITE; req_addr = 4'd3; req_wdata = 32'h0000_1234;
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", rsp_data, model[3]);
    end
    req_valid = 1'b0;
    a_collect("stall");
    @(negedge clk);
    check("stall_single_count", 32'(rsp_count), 32'(exp_count));
    a_read("read3_after_ignored_write", OP_READ, 4'd3);

    // Reset while the RMW is in READ: no write-back must land
    a_write(4'd2, 32'h0000_0010);
    a_send(OP_RMW_INC, 4'd2, '0);
    rst_n = 1'b0;
    #1;
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_rsp_count", 32'(rsp_count), 32'd0);
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    a_read("read2_no_wb", OP_READ, 4'd2);

    // Narrow instance: back-to-back writes, then read each back
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("b_wr_ready", 32'(b_req_ready), 32'd1);
      b_req_valid = 1'b1; b_req_op = OP_WRITE; b_req_addr = BAW'(i); b_req_wdata = bvals[i];
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_req_valid = 1'b1; b_req_op = OP_READ; b_req_addr = BAW'(i);
      @(negedge clk);
      b_req_valid = 1'b0;
      n = 0;
      while (!b_rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b_rsp_valid", 32'(b_rsp_valid), 32'd1);
      check("b_rsp_data", 32'(b_rsp_data), 32'(bvals[i]));
      @(negedge clk);
    end
    check("b_rsp_count", 32'(b_rsp_count), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
